// File: rtl/key_command_decoder.sv
// key_command_decoder
// Synchronises and debounces three active-low pushbuttons. Each accepted
// press turns into a command: KEY[0] cycles the colour mode, KEY[1] steps
// the blink speed and KEY[2] toggles pause. All outputs are registered.

module key_command_decoder #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int BASE_HALF_PERIOD = 25000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [2:0]  KEY,
    output logic [1:0]  MODE,
    output logic [1:0]  SPEED,
    output logic        PAUSE,
    output logic [31:0] HALF_PERIOD,
    output logic        CMD_VALID,
    output logic [1:0]  CMD_CODE
);

    // The counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      BASE_HP = 32'(BASE_HALF_PERIOD);

    // Colour-mode states.
    localparam logic [1:0] MODE_GREEN = 2'd0;
    localparam logic [1:0] MODE_RED   = 2'd1;
    localparam logic [1:0] MODE_BOTH  = 2'd2;

    // Next colour mode in the green -> red -> both -> green cycle.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            MODE_GREEN: nxt = MODE_RED;
            MODE_RED:   nxt = MODE_BOTH;
            MODE_BOTH:  nxt = MODE_GREEN;
            default:    nxt = MODE_GREEN;
        endcase
        return nxt;
    endfunction

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       stable_r;
    logic [CNT_W-1:0] cnt_r     [3];
    logic [2:0]       stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s [3];
    logic [2:0]       press_s;

    logic [1:0]       mode_r;
    logic [1:0]       speed_r;
    logic             pause_r;
    logic [31:0]      half_period_r;
    logic             cmd_valid_r;
    logic [1:0]       cmd_code_r;

    logic [1:0]       mode_nxt_s;
    logic [1:0]       speed_nxt_s;
    logic             pause_nxt_s;
    logic [1:0]       code_nxt_s;

    // Two-flop synchroniser on the raw asynchronous keys.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debounce: a new level is accepted once it has disagreed with
    // the stable level for DEBOUNCE_CYCLES consecutive synced cycles.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int k = 0; k < 3; k++) begin
            cnt_nxt_s[k] = '0;
            if (sync2_r[k] == stable_r[k]) begin
                cnt_nxt_s[k] = '0;
            end else if (cnt_r[k] != CNT_MAX) begin
                cnt_nxt_s[k] = cnt_r[k] + CNT_W'(1);
            end else begin
                stable_nxt_s[k] = sync2_r[k];
                cnt_nxt_s[k]    = '0;
            end
        end
        // Only the 1 -> 0 transition of the stable level is a press.
        press_s = stable_r & ~stable_nxt_s;
    end

    // Debounce state registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stable_r <= 3'b111;
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    // Command decode: every simultaneous press is applied, and the reported
    // source is the lowest-numbered key that fired.
    always_comb begin
        mode_nxt_s  = press_s[0] ? next_mode(mode_r) : mode_r;
        speed_nxt_s = press_s[1] ? (speed_r + 2'd1) : speed_r;
        pause_nxt_s = press_s[2] ? ~pause_r : pause_r;
        if (press_s[0]) begin
            code_nxt_s = 2'd0;
        end else if (press_s[1]) begin
            code_nxt_s = 2'd1;
        end else if (press_s[2]) begin
            code_nxt_s = 2'd2;
        end else begin
            code_nxt_s = cmd_code_r;
        end
    end

    // Command output registers; HALF_PERIOD follows SPEED on the same edge.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_r        <= MODE_GREEN;
            speed_r       <= 2'd0;
            pause_r       <= 1'b0;
            half_period_r <= BASE_HP;
            cmd_valid_r   <= 1'b0;
            cmd_code_r    <= 2'd0;
        end else begin
            mode_r        <= mode_nxt_s;
            speed_r       <= speed_nxt_s;
            pause_r       <= pause_nxt_s;
            half_period_r <= BASE_HP >> speed_nxt_s;
            cmd_valid_r   <= |press_s;
            cmd_code_r    <= code_nxt_s;
        end
    end

    assign MODE        = mode_r;
    assign SPEED       = speed_r;
    assign PAUSE       = pause_r;
    assign HALF_PERIOD = half_period_r;
    assign CMD_VALID   = cmd_valid_r;
    assign CMD_CODE    = cmd_code_r;

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed testbench for key_command_decoder with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point after later edges. A held key is therefore accepted on the sixth
// edge after it is driven low (2 synchroniser edges + 4 debounce edges).

module tb_key_command_decoder;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [2:0]  KEY;
    logic [1:0]  MODE;
    logic [1:0]  SPEED;
    logic        PAUSE;
    logic [31:0] HALF_PERIOD;
    logic        CMD_VALID;
    logic [1:0]  CMD_CODE;

    int checks_r   = 0;
    int failures_r = 0;
    int valid_cnt_r = 0;
    bit mode3_seen_r = 1'b0;

    key_command_decoder #(
        .DEBOUNCE_CYCLES (4),
        .BASE_HALF_PERIOD(25000000)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .KEY        (KEY),
        .MODE       (MODE),
        .SPEED      (SPEED),
        .PAUSE      (PAUSE),
        .HALF_PERIOD(HALF_PERIOD),
        .CMD_VALID  (CMD_VALID),
        .CMD_CODE   (CMD_CODE)
    );

    // 50 MHz clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Pulse counter and illegal-mode monitor, sampled on the falling edge.
    always @(negedge CLOCK_50) begin
        if (CMD_VALID === 1'b1) valid_cnt_r++;
        if (MODE === 2'd3) mode3_seen_r = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick(1);
    endtask

    // Full debounced press and release of one key.
    task automatic press(input int k);
        KEY[k] = 1'b0;
        tick(10);
        KEY[k] = 1'b1;
        tick(10);
    endtask

    logic [1:0]  exp_speed [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_half  [4] = '{32'd12500000, 32'd6250000, 32'd3125000, 32'd25000000};
    logic [1:0]  exp_mode  [3] = '{2'd1, 2'd2, 2'd0};

    initial begin
        RESET_N = 1'b0;
        KEY     = 3'b111;
        tick(2);
        check_val("rst_mode",  32'(MODE), 32'd0);
        check_val("rst_speed", 32'(SPEED), 32'd0);
        check_val("rst_pause", 32'(PAUSE), 32'd0);
        check_val("rst_half",  HALF_PERIOD, 32'd25000000);
        check_val("rst_valid", 32'(CMD_VALID), 32'd0);
        check_val("rst_code",  32'(CMD_CODE), 32'd0);
        RESET_N = 1'b1;
        tick(2);

        // Scenario 1: single held press, no event on release.
        valid_cnt_r = 0;
        KEY[0] = 1'b0;
        tick(5);
        check_val("s1_mode_e5",  32'(MODE), 32'd0);
        check_val("s1_valid_e5", 32'(CMD_VALID), 32'd0);
        tick(1);
        check_val("s1_mode_e6",  32'(MODE), 32'd1);
        check_val("s1_valid_e6", 32'(CMD_VALID), 32'd1);
        check_val("s1_code_e6",  32'(CMD_CODE), 32'd0);
        tick(1);
        check_val("s1_valid_e7", 32'(CMD_VALID), 32'd0);
        tick(13);
        KEY[0] = 1'b1;
        tick(12);
        check_val("s1_mode_rel",  32'(MODE), 32'd1);
        check_val("s1_pulses",    valid_cnt_r, 32'd1);

        // Scenario 2: glitches shorter than the debounce window.
        do_reset();
        valid_cnt_r = 0;
        KEY[0] = 1'b0; tick(3);
        KEY[0] = 1'b1; tick(2);
        KEY[0] = 1'b0; tick(3);
        KEY[0] = 1'b1; tick(10);
        check_val("s2_mode",   32'(MODE), 32'd0);
        check_val("s2_pulses", valid_cnt_r, 32'd0);

        // Scenario 3: speed steps and half-period table, with wrap.
        for (int i = 0; i < 4; i++) begin
            press(1);
            check_val($sformatf("s3_speed%0d", i), 32'(SPEED), 32'(exp_speed[i]));
            check_val($sformatf("s3_half%0d", i), HALF_PERIOD, exp_half[i]);
        end
        check_val("s3_code", 32'(CMD_CODE), 32'd1);

        // Scenario 4: KEY[0] and KEY[2] together; CMD_CODE starts at 1.
        do_reset();
        press(1);
        valid_cnt_r = 0;
        KEY = 3'b010;
        tick(5);
        check_val("s4_pause_e5", 32'(PAUSE), 32'd0);
        tick(1);
        check_val("s4_mode",  32'(MODE), 32'd1);
        check_val("s4_pause", 32'(PAUSE), 32'd1);
        check_val("s4_valid", 32'(CMD_VALID), 32'd1);
        check_val("s4_code",  32'(CMD_CODE), 32'd0);
        tick(1);
        check_val("s4_valid_off", 32'(CMD_VALID), 32'd0);
        KEY = 3'b111;
        tick(10);
        check_val("s4_pulses", valid_cnt_r, 32'd1);

        // Scenario 5: mode cycles back to green, never 3.
        do_reset();
        mode3_seen_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            press(0);
            check_val($sformatf("s5_mode%0d", i), 32'(MODE), 32'(exp_mode[i]));
        end
        check_val("s5_no_mode3", 32'(mode3_seen_r), 32'd0);
        press(2);
        check_val("s5_pause", 32'(PAUSE), 32'd1);
        check_val("s5_code2", 32'(CMD_CODE), 32'd2);
        tick(20);
        check_val("s5_code_hold", 32'(CMD_CODE), 32'd2);

        // Back-to-back pulses from presses one edge apart.
        KEY[0] = 1'b0;
        tick(1);
        KEY[1] = 1'b0;
        tick(5);
        check_val("b2b_valid0", 32'(CMD_VALID), 32'd1);
        check_val("b2b_code0",  32'(CMD_CODE), 32'd0);
        check_val("b2b_mode",   32'(MODE), 32'd1);
        tick(1);
        check_val("b2b_valid1", 32'(CMD_VALID), 32'd1);
        check_val("b2b_code1",  32'(CMD_CODE), 32'd1);
        check_val("b2b_speed",  32'(SPEED), 32'd1);
        tick(1);
        check_val("b2b_valid2", 32'(CMD_VALID), 32'd0);
        KEY = 3'b111;
        tick(10);

        // Scenario 6: reset during a debounce of KEY[1]; SPEED starts at 1.
        KEY[1] = 1'b0;
        tick(3);
        RESET_N = 1'b0;
        #1;
        check_val("s6_rst_speed", 32'(SPEED), 32'd0);
        check_val("s6_rst_mode",  32'(MODE), 32'd0);
        check_val("s6_rst_pause", 32'(PAUSE), 32'd0);
        check_val("s6_rst_half",  HALF_PERIOD, 32'd25000000);
        check_val("s6_rst_code",  32'(CMD_CODE), 32'd0);
        tick(2);
        check_val("s6_rst_valid", 32'(CMD_VALID), 32'd0);
        valid_cnt_r = 0;
        RESET_N = 1'b1;
        tick(5);
        check_val("s6_speed_e5",  32'(SPEED), 32'd0);
        check_val("s6_pulses_e5", valid_cnt_r, 32'd0);
        tick(1);
        check_val("s6_speed_e6", 32'(SPEED), 32'd1);
        check_val("s6_half_e6",  HALF_PERIOD, 32'd12500000);
        check_val("s6_valid_e6", 32'(CMD_VALID), 32'd1);
        KEY = 3'b111;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of cycles a key must hold a new level before it is accepted (20 ms at 50 MHz).
REQ-002 SHALL provide parameter BASE_HALF_PERIOD, default 25000000, meaning the blink half-period in cycles at speed 0.
REQ-003 CLOCK_50  input  1  system clock; all flops on its rising edge.
REQ-004 RESET_N  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 KEY  input  3  raw pushbuttons; active-low (0 = pressed); asynchronous to CLOCK_50.
REQ-006 MODE  output  2  colour mode: 0 = green, 1 = red, 2 = both; 3 is never driven.
REQ-007 SPEED  output  2  blink speed index, 0 (slowest) to 3.
REQ-008 PAUSE  output  1  1 = blinking frozen.
REQ-009 HALF_PERIOD  output  32  BASE_HALF_PERIOD >> SPEED.
REQ-010 CMD_VALID  output  1  one-cycle pulse on each accepted command.
REQ-011 CMD_CODE  output  2  source of the last command: 0 = KEY[0], 1 = KEY[1], 2 = KEY[2].

Function
REQ-012 Each KEY bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each key SHALL have an independent stable level (reset 1) and a debounce counter wide enough for DEBOUNCE_CYCLES-1.
REQ-014 Counter rule per key: synced level equals stable -> counter cleared to 0; differs and counter < DEBOUNCE_CYCLES-1 -> counter + 1; differs and counter == DEBOUNCE_CYCLES-1 -> stable takes synced level, counter cleared.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL leave stable unchanged, and the counter SHALL restart from 0 on the next disagreement.
REQ-016 A press event SHALL be the edge at which stable goes 1 -> 0; a release (0 -> 1) SHALL produce no event.
REQ-017 Key held low continuously from edge 0: stable, command outputs and CMD_VALID SHALL update at edge 2+DEBOUNCE_CYCLES.
REQ-018 KEY[0] press: MODE 0->1->2->0.
REQ-019 KEY[1] press: SPEED + 1 modulo 4 (3 wraps to 0); HALF_PERIOD updates on the same edge.
REQ-020 KEY[2] press: PAUSE toggles.
REQ-021 A held key SHALL yield exactly one command, with no auto-repeat.
REQ-022 Simultaneous press events on several keys at one edge SHALL all be applied.
REQ-023 In that case, CMD_VALID SHALL be a single one-cycle pulse and CMD_CODE SHALL report the lowest-numbered key.
REQ-024 CMD_VALID SHALL be high only in the cycle after the edge that applied a command; press events on consecutive edges SHALL produce back-to-back pulses.
REQ-025 CMD_CODE SHALL hold its value until the next command.
REQ-026 HALF_PERIOD SHALL be registered: 25000000, 12500000, 6250000, 3125000 for SPEED 0..3 at default parameters.

Reset
REQ-027 RESET_N low SHALL immediately force: synchronizers and stable levels = 1; counters = 0; MODE = 0; SPEED = 0; PAUSE = 0; HALF_PERIOD = BASE_HALF_PERIOD; CMD_VALID = 0; CMD_CODE = 0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no command SHALL be emitted for that press.
REQ-029 After reset release, a key already held low SHALL be accepted as a new press after the full 2+DEBOUNCE_CYCLES latency.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Scenario 1: KEY[0] low for 20 cycles, then high -> MODE 0->1 exactly 6 edges after first low sample; one CMD_VALID pulse with CMD_CODE = 0; no event on release.
REQ-031 Scenario 2: KEY[0] pulsed low 3 cycles, high 2, low 3 -> MODE stays 0; CMD_VALID never asserts.
REQ-032 Scenario 3: four separate debounced KEY[1] presses -> SPEED 1, 2, 3, 0; HALF_PERIOD 12500000, 6250000, 3125000, 25000000.
REQ-033 Scenario 4: KEY[0] and KEY[2] low on the same cycle -> MODE = 1 and PAUSE = 1 on the same edge; one CMD_VALID pulse with CMD_CODE = 0.
REQ-034 Scenario 5: three KEY[0] presses -> MODE returns to 0; MODE never reads 3.
REQ-035 Scenario 6: KEY[1] low, RESET_N pulsed low after 3 cycles, KEY[1] kept low -> all outputs at reset values during reset; SPEED = 1 exactly 6 edges after release.
